// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcode/funct constants, FSM state encoding and
//               instruction-class helpers for the R-type issue block.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam logic [5:0] c_OP_RTYPE = 6'h00;

  localparam logic [5:0] c_FN_SLL  = 6'h00;
  localparam logic [5:0] c_FN_SRL  = 6'h02;
  localparam logic [5:0] c_FN_SRA  = 6'h03;
  localparam logic [5:0] c_FN_MFHI = 6'h10;
  localparam logic [5:0] c_FN_MFLO = 6'h12;
  localparam logic [5:0] c_FN_MULT = 6'h18;
  localparam logic [5:0] c_FN_DIV  = 6'h1A;
  localparam logic [5:0] c_FN_ADD  = 6'h20;
  localparam logic [5:0] c_FN_SUB  = 6'h22;
  localparam logic [5:0] c_FN_AND  = 6'h24;
  localparam logic [5:0] c_FN_OR   = 6'h25;
  localparam logic [5:0] c_FN_XOR  = 6'h26;
  localparam logic [5:0] c_FN_NOR  = 6'h27;
  localparam logic [5:0] c_FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_GO   = 3'd2,
    ST_WAIT = 3'd3,
    ST_WB   = 3'd4
  } state_t;

  // Functs whose ALU result lands in R[rd].
  function automatic logic fn_writes_rd(input logic [5:0] fn);
    case (fn)
      c_FN_SLL, c_FN_SRL, c_FN_SRA, c_FN_MFHI, c_FN_MFLO,
      c_FN_ADD, c_FN_SUB, c_FN_AND, c_FN_OR, c_FN_XOR,
      c_FN_NOR, c_FN_SLT: return 1'b1;
      default:            return 1'b0;
    endcase
  endfunction

  // mult/div are legal but keep their result inside the ALU (hi/lo).
  function automatic logic fn_is_legal(input logic [5:0] op, input logic [5:0] fn);
    return (op == c_OP_RTYPE) &&
           (fn_writes_rd(fn) || (fn == c_FN_MULT) || (fn == c_FN_DIV));
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module      : regfile
// Description : 32x32 register file, R0 hard-wired to zero. Two
//               combinational operand reads, one debug read, one
//               synchronous write. Reads never bypass a same-cycle write.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile #(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr_a,
  input  logic [4:0]  i_raddr_b,
  input  logic [4:0]  i_dbg_addr,
  output logic [31:0] o_rdata_a,
  output logic [31:0] o_rdata_b,
  output logic [31:0] o_dbg_data
);

  logic [31:0] r_mem [NREGS];

  // Storage: cleared on reset, single write port; R0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = (i_raddr_a  == 5'd0) ? 32'd0 : r_mem[i_raddr_a];
  assign o_rdata_b  = (i_raddr_b  == 5'd0) ? 32'd0 : r_mem[i_raddr_b];
  assign o_dbg_data = (i_dbg_addr == 5'd0) ? 32'd0 : r_mem[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/rtype_issue.sv
`default_nettype none
// ============================================================================
// Module      : rtype_issue
// Description : Issues one MIPS R-type instruction at a time: reads rs/rt,
//               pulses the external ALU, then writes the result to rd.
//               Fixed 5-cycle occupancy per instruction, no forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module rtype_issue
  import cpu_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  output logic [5:0]  alu_funct,
  output logic        alu_go,
  input  logic [31:0] alu_out,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        err,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  state_t      r_state;
  logic [31:0] r_instr;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [4:0]  r_alu_shamt;
  logic [5:0]  r_alu_funct;
  logic        r_alu_go;
  logic        r_wb_valid;
  logic [4:0]  r_wb_addr;
  logic        r_err;

  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic        w_legal;
  logic        w_writes;
  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;

  assign w_op     = r_instr[31:26];
  assign w_rs     = r_instr[25:21];
  assign w_rt     = r_instr[20:16];
  assign w_rd     = r_instr[15:11];
  assign w_legal  = fn_is_legal(w_op, r_instr[5:0]);
  assign w_writes = w_legal && fn_writes_rd(r_instr[5:0]);

  regfile #(
    .NREGS (NREGS)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .i_we       (r_wb_valid),
    .i_waddr    (r_wb_addr),
    .i_wdata    (alu_out),
    .i_raddr_a  (w_rs),
    .i_raddr_b  (w_rt),
    .i_dbg_addr (dbg_addr),
    .o_rdata_a  (w_rs_data),
    .o_rdata_b  (w_rt_data),
    .o_dbg_data (dbg_data)
  );

  // Issue sequencer: every strobe is registered one state ahead so it is
  // visible during the state it belongs to (alu_go in GO, wb_valid/err in WB).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_instr     <= 32'd0;
      r_alu_a     <= 32'd0;
      r_alu_b     <= 32'd0;
      r_alu_shamt <= 5'd0;
      r_alu_funct <= 6'd0;
      r_alu_go    <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_addr   <= 5'd0;
      r_err       <= 1'b0;
    end else begin
      r_alu_go   <= 1'b0;
      r_wb_valid <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (instr_valid) begin
            r_instr <= instr;
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          r_alu_a     <= w_rs_data;
          r_alu_b     <= w_rt_data;
          r_alu_shamt <= r_instr[10:6];
          r_alu_funct <= r_instr[5:0];
          r_alu_go    <= w_legal;
          r_state     <= ST_GO;
        end
        ST_GO: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // rd = 0 is a legal target but the write is dropped entirely.
          r_wb_valid <= w_writes && (w_rd != 5'd0);
          r_wb_addr  <= w_rd;
          r_err      <= !w_legal;
          r_state    <= ST_WB;
        end
        ST_WB: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = (r_state == ST_IDLE);
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_shamt   = r_alu_shamt;
  assign alu_funct   = r_alu_funct;
  assign alu_go      = r_alu_go;
  assign wb_valid    = r_wb_valid;
  assign wb_addr     = r_wb_addr;
  // ALU result is taken live during WB; zero outside the write strobe.
  assign wb_data     = r_wb_valid ? alu_out : 32'd0;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rtype_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtype_issue
// Description : Scoreboard bench for rtype_issue with a behavioural ALU and
//               an instruction-level reference model of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtype_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_shamt;
  logic [5:0]  alu_funct;
  logic        alu_go;
  logic [31:0] alu_out;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        err;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          cyc;
    int          kind;   // 0 = alu_go, 1 = register write, 2 = err
    logic [4:0]  addr;
    logic [31:0] data;
  } ev_t;
  ev_t q[$];

  logic [31:0] ref_r [32];
  logic [31:0] ref_hi = 32'd0, ref_lo = 32'd0;
  logic [31:0] env_hi = 32'd0, env_lo = 32'd0;

  rtype_issue #(.NREGS(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_shamt   (alu_shamt),
    .alu_funct   (alu_funct),
    .alu_go      (alu_go),
    .alu_out     (alu_out),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .err         (err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  // Cycle index: the value cyc holds during a cycle is the edge that opened it.
  always @(posedge clk) cyc <= cyc + 1;

  // Behaviour of a MIPS integer ALU for the result-producing functs.
  function automatic logic [31:0] alu_fn(input logic [5:0] f, input logic [31:0] a, b,
                                         input logic [4:0] sh, input logic [31:0] hi, lo);
    case (f)
      6'h00: return b << sh;
      6'h02: return b >> sh;
      6'h03: return $signed(b) >>> sh;
      6'h10: return hi;
      6'h12: return lo;
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // {hi, lo} after mult (signed) or div (unsigned, divide-by-zero gives 0).
  function automatic logic [63:0] muldiv(input logic [5:0] f, input logic [31:0] a, b);
    logic signed [63:0] p;
    if (f == 6'h18) begin
      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      return p;
    end
    if (b == 32'd0) return 64'd0;
    return {a % b, a / b};
  endfunction

  always_comb alu_out = alu_fn(alu_funct, alu_a, alu_b, alu_shamt, env_hi, env_lo);

  // ALU hi/lo update on the trigger pulse.
  always @(posedge clk) begin
    if (alu_go && (alu_funct == 6'h18 || alu_funct == 6'h1A))
      {env_hi, env_lo} <= muldiv(alu_funct, alu_a, alu_b);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_event(input int kind, input logic [4:0] a, input logic [31:0] d);
    n_tests++;
    if (q.size() == 0 || q[0].kind != kind || q[0].cyc != cyc) begin
      n_fail++;
      $display("FAIL unexpected_strobe: kind %0d at cycle %0d, expected kind %0d at cycle %0d",
               kind, cyc, (q.size() != 0) ? q[0].kind : -1, (q.size() != 0) ? q[0].cyc : -1);
    end else begin
      if (kind == 1 && (a !== q[0].addr || d !== q[0].data)) begin
        n_fail++;
        $display("FAIL wb_write: got R%0d=%h expected R%0d=%h", a, d, q[0].addr, q[0].data);
      end
      void'(q.pop_front());
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL missed_strobe: kind %0d due cycle %0d, now %0d", q[0].kind, q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (alu_go)   mon_event(0, 5'd0, 32'd0);
    if (wb_valid) mon_event(1, wb_addr, wb_data);
    if (err)      mon_event(2, 5'd0, 32'd0);
  end

  // Reference model: applies the instruction architecturally and queues the
  // strobes it must produce, relative to the acceptance edge h.
  task automatic model_push(input logic [31:0] w, input int h,
                            output bit legal, output logic [31:0] ea, eb);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] res;
    op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sh = w[10:6]; fn = w[5:0];
    ea = ref_r[rs];
    eb = ref_r[rt];
    legal = (op == 6'h00) && (fn inside {6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h18, 6'h1A,
                                         6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A});
    if (!legal) begin
      q.push_back('{cyc: h + 3, kind: 2, addr: 5'd0, data: 32'd0});
    end else begin
      q.push_back('{cyc: h + 1, kind: 0, addr: 5'd0, data: 32'd0});
      if (fn == 6'h18 || fn == 6'h1A) begin
        {ref_hi, ref_lo} = muldiv(fn, ea, eb);
      end else begin
        res = alu_fn(fn, ea, eb, sh, ref_hi, ref_lo);
        if (rd != 5'd0) begin
          q.push_back('{cyc: h + 3, kind: 1, addr: rd, data: res});
          ref_r[rd] = res;
        end
      end
    end
  endtask

  // Offer one instruction at an idle cycle and follow it to retirement.
  // With noisy set, instr_valid stays high with junk words while busy.
  task automatic issue(input logic [5:0] op, input logic [4:0] rs, rt, rd, sh,
                       input logic [5:0] fn, input bit noisy);
    logic [31:0] w, ea, eb, old_rd;
    bit legal;
    int h;
    w = {op, rs, rt, rd, sh, fn};
    dbg_addr = rd;
    old_rd = ref_r[rd];
    chk("ready_idle", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr = w;
    h = cyc + 1;
    model_push(w, h, legal, ea, eb);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      instr_valid = noisy;
      instr = $urandom;
      chk("ready_busy", {31'd0, instr_ready}, 32'd0);
      if (legal && (k == 1 || k == 3)) begin
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_ctl", {21'd0, alu_shamt, alu_funct}, {21'd0, sh, fn});
      end
      if (k == 3) chk("dbg_no_bypass", dbg_data, old_rd);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    chk("dbg_after_wb", dbg_data, ref_r[rd]);
  endtask

  task automatic dbg_check(input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk("dbg_const", dbg_data, exp);
  endtask

  initial begin
    logic [5:0] fl [14];
    logic [5:0] rop, rfn;
    logic [31:0] w;
    int h;
    bit legal;
    logic [31:0] ea, eb;

    fl = '{6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h18, 6'h1A,
           6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
    for (int i = 0; i < 32; i++) ref_r[i] = 32'd0;
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = 32'd0;
    dbg_addr = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_ready", {31'd0, instr_ready}, 32'd1);
    chk("reset_alu_ab", alu_a | alu_b, 32'd0);
    chk("reset_alu_ctl", {21'd0, alu_shamt, alu_funct}, 32'd0);
    chk("reset_strobes", {29'd0, alu_go, wb_valid, err}, 32'd0);
    chk("reset_wb", {27'd0, wb_addr} | wb_data, 32'd0);

    // Build constants R1=5, R2=7 using only R-type operations.
    issue(6'h00, 5'd0, 5'd0, 5'd6, 5'd0, 6'h27, 1'b0);   // R6 = -1
    issue(6'h00, 5'd0, 5'd6, 5'd7, 5'd0, 6'h22, 1'b0);   // R7 = 1
    issue(6'h00, 5'd0, 5'd7, 5'd1, 5'd2, 6'h00, 1'b0);   // R1 = 4
    issue(6'h00, 5'd1, 5'd7, 5'd1, 5'd0, 6'h20, 1'b0);   // R1 = 5
    issue(6'h00, 5'd0, 5'd7, 5'd2, 5'd3, 6'h00, 1'b0);   // R2 = 8
    issue(6'h00, 5'd2, 5'd7, 5'd2, 5'd0, 6'h22, 1'b0);   // R2 = 7
    dbg_check(5'd1, 32'd5);
    dbg_check(5'd2, 32'd7);

    issue(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 1'b0);   // add R3 = 12
    dbg_check(5'd3, 32'd12);
    issue(6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20, 1'b0);   // add to R0
    dbg_check(5'd0, 32'd0);
    issue(6'h23, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 1'b0);   // non-R-type opcode
    issue(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h01, 1'b0);   // unlisted funct
    dbg_check(5'd3, 32'd12);

    issue(6'h00, 5'd0, 5'd7, 5'd1, 5'd31, 6'h00, 1'b0);  // R1 = 0x80000000
    issue(6'h00, 5'd0, 5'd1, 5'd4, 5'd4, 6'h03, 1'b0);   // sra R4
    dbg_check(5'd4, 32'hF800_0000);
    issue(6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h18, 1'b0);   // mult R1*R2
    issue(6'h00, 5'd0, 5'd0, 5'd8, 5'd0, 6'h10, 1'b0);   // mfhi R8
    dbg_check(5'd8, 32'hFFFF_FFFC);

    issue(6'h00, 5'd2, 5'd7, 5'd5, 5'd0, 6'h22, 1'b1);   // sub R5 = 6
    issue(6'h00, 5'd5, 5'd2, 5'd9, 5'd0, 6'h2A, 1'b1);   // slt R9 = (6 < 7)
    dbg_check(5'd5, 32'd6);
    dbg_check(5'd9, 32'd1);

    // Randomized instruction stream, with occasional illegal words.
    @(negedge clk);
    for (int i = 0; i < 150; i++) begin
      rop = ($urandom_range(0, 11) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
      rfn = ($urandom_range(0, 11) == 0) ? 6'h01 : fl[$urandom_range(0, 13)];
      issue(rop, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), rfn, 1'($urandom));
    end

    // Reset during GO aborts the instruction.
    w = {6'h00, 5'd2, 5'd2, 5'd11, 5'd0, 6'h20};
    instr_valid = 1'b1;
    instr = w;
    h = cyc + 1;
    model_push(w, h, legal, ea, eb);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);                 // GO cycle
    while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) ref_r[i] = 32'd0;
    chk("abort_ready", {31'd0, instr_ready}, 32'd1);
    chk("abort_outputs", alu_a | alu_b | {21'd0, alu_shamt, alu_funct}, 32'd0);
    for (int i = 0; i < 32; i++) dbg_check(5'(i), 32'd0);
    @(negedge clk);
    issue(6'h00, 5'd0, 5'd0, 5'd6, 5'd0, 6'h27, 1'b0);   // life after reset
    repeat (6) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/rtype_issue.md
RTYPE_ISSUE -- requirements
Module: rtype_issue

Interface
REQ-001 SHALL have parameter NREGS, default 32, meaning register-file depth (fixed at 32, 5-bit addresses).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port instr_valid, input, 1, instruction offered.
REQ-005 SHALL have port instr, input, 32, MIPS word: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0].
REQ-006 SHALL have port instr_ready, output, 1, block can accept an instruction.
REQ-007 SHALL have ports alu_a and alu_b, output, 32 each, carrying the rs and rt operands to the ALU.
REQ-008 SHALL have ports alu_shamt (output, 5) and alu_funct (output, 6), both to the ALU.
REQ-009 SHALL have port alu_go, output, 1, ALU trigger pulse.
REQ-010 SHALL have port alu_out, input, 32, ALU result.
REQ-011 SHALL have port wb_valid, output, 1, one-cycle register-write strobe.
REQ-012 SHALL have ports wb_addr (output, 5) and wb_data (output, 32), the write target and its value.
REQ-013 SHALL have port err, output, 1, one-cycle illegal-instruction strobe.
REQ-014 SHALL have ports dbg_addr (input, 5) and dbg_data (output, 32), a combinational register read.

Function
REQ-015 SHALL implement FSM IDLE -> READ -> GO -> WAIT -> WB -> IDLE, one cycle per state except IDLE.
REQ-016 SHALL assert instr_ready only in IDLE; a handshake is instr_valid && instr_ready at a clock edge.
REQ-017 SHALL, on handshake, latch instr and enter READ; instr changes outside a handshake SHALL be ignored.
REQ-018 SHALL, in READ, latch alu_a = R[rs] and alu_b = R[rt], with R[0] reading 0.
REQ-019 SHALL drive alu_shamt and alu_funct from the latched instruction and hold alu_a, alu_b, alu_shamt and alu_funct stable from GO through WB.
REQ-020 SHALL assert alu_go high only during GO, giving exactly one one-cycle pulse per instruction with alu_go low otherwise.
REQ-021 SHALL sample alu_out in WB, so a handshake at edge N produces wb_valid during cycle N+4 and instr_ready again at cycle N+5.
REQ-022 SHALL, in WB, write R[rd] = alu_out and pulse wb_valid with wb_addr = rd, for funct in {00,02,03,10,12,20,22,24,25,26,27,2A}.
REQ-023 SHALL, for funct 18 (mult) or 1A (div), still pulse alu_go but suppress the register write and wb_valid; hi/lo remain in the ALU.
REQ-024 SHALL never write R[0]; when rd = 0, wb_valid SHALL stay low.
REQ-025 SHALL treat op != 0 or an unlisted funct as illegal: no alu_go, no write, err pulsed in the WB-slot cycle, same latency.
REQ-026 SHALL return the register value as it was before the current clock's write when dbg_addr is written in the same cycle (no bypass).
REQ-027 SHALL not forward between instructions; the next instruction's READ SHALL observe the previous WB write because the write commits at the WB edge.

Reset
REQ-028 SHALL, on reset, set the FSM to IDLE, clear all 32 registers to 0, and drive alu_a, alu_b, alu_shamt, alu_funct, alu_go, wb_valid, wb_addr, wb_data and err to 0.
REQ-029 SHALL abort any in-flight instruction on reset with no write, no err and no further alu_go; instr_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-030 SHALL give reset priority over a simultaneous handshake.

Structure
REQ-031 SHALL place funct codes, the opcode R-type constant and the FSM state encoding in shared package cpu_pkg.
REQ-032 SHALL implement the register file as sub-module regfile (two combinational read ports, one synchronous write port, plus the debug read port).

Verification
REQ-033 SHALL verify: R1=5, R2=7 preloaded; instr add rd=3 (funct 20) -> alu_go at N+2, wb_valid at N+4, wb_addr=3, wb_data=12, dbg R3=12.
REQ-034 SHALL verify: R1=0x80000000; sra rd=4, shamt=4 (funct 03) -> wb_data matches ALU result; then mfhi (funct 10) after mult R1*R2 -> mult gives no wb_valid, mfhi writes the ALU hi.
REQ-035 SHALL verify: add with rd=0 -> alu_go pulses, wb_valid low, R0 still reads 0.
REQ-036 SHALL verify: op=0x23 or funct=0x01 -> no alu_go, err at N+4, no register change, ready at N+5.
REQ-037 SHALL verify: back-to-back sub rd=5 then slt using rs=5 -> second instruction reads the updated R5; instr_valid held high with the instruction changed mid-flight -> only accepted words execute.
REQ-038 SHALL verify: reset asserted during GO -> no wb_valid, all registers 0, instr_ready=1 the cycle after deassert.
